// File: rtl/seven_seg_scan_driver_if.sv
// Bundle between the CPU-side Seven_seg source and the display scan driver.
// The master owns enable and the packed patterns; the slave drives the display pins.
interface seven_seg_scan_driver_if;
  logic        en;
  logic [27:0] seven_seg;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  modport master (
    output en,
    output seven_seg,
    input  an,
    input  seg,
    input  digit_idx,
    input  frame_tick
  );

  modport slave (
    input  en,
    input  seven_seg,
    output an,
    output seg,
    output digit_idx,
    output frame_tick
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Four-digit 7-segment scan driver: one blank + on slot per digit, with the
// pattern word snapshotted once per frame so a digit never shows a torn update.
module seven_seg_scan_driver #(
  parameter int CLK_DIV          = 50000,
  parameter int BLANK_CYCLES     = 500,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input logic                    clk,
  input logic                    rst_n,
  seven_seg_scan_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  localparam int             CW         = $clog2(CLK_DIV);
  localparam logic [3:0]     AN_OFF     = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0]     SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]  SLOT_LAST  = CW'(CLK_DIV - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    idx, idx_next;
  logic [27:0]   snap, snap_next;
  logic          tick, tick_next;
  logic [3:0]    an_q, an_next;
  logic [6:0]    seg_q, seg_next;

  function automatic logic [3:0] anode_drive(input logic [1:0] k);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << k;
    return ANODE_ACTIVE_LOW ? ~one_hot : one_hot;
  endfunction

  function automatic logic [6:0] seg_drive(input logic [27:0] pat, input logic [1:0] k);
    logic [6:0] p;
    p = pat[7*k +: 7];
    return SEG_ACTIVE_LOW ? ~p : p;
  endfunction

  // Outputs are computed for the next state so they register on the same edge.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    snap_next  = snap;
    tick_next  = 1'b0;
    an_next    = AN_OFF;
    seg_next   = SEG_OFF;

    if (!bus.en) begin
      state_next = IDLE;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = BLANK;
          cnt_next   = '0;
          idx_next   = '0;
          snap_next  = bus.seven_seg;
          tick_next  = 1'b1;
        end
        BLANK: begin
          cnt_next = cnt + 1'b1;
          if (cnt == BLANK_LAST) begin
            state_next = ON;
            an_next    = anode_drive(idx);
            seg_next   = seg_drive(snap, idx);
          end
        end
        ON: begin
          if (cnt == SLOT_LAST) begin
            state_next = BLANK;
            cnt_next   = '0;
            idx_next   = idx + 1'b1;
            // Leaving digit 3 starts a new frame: take the fresh snapshot here.
            if (idx == 2'd3) begin
              snap_next = bus.seven_seg;
              tick_next = 1'b1;
            end
          end else begin
            cnt_next = cnt + 1'b1;
            an_next  = anode_drive(idx);
            seg_next = seg_drive(snap, idx);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      snap  <= '0;
      tick  <= 1'b0;
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      snap  <= snap_next;
      tick  <= tick_next;
      an_q  <= an_next;
      seg_q <= seg_next;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.digit_idx  = idx;
  assign bus.frame_tick = tick;

  // Display safety: never two digits at once, never lit outside the ON phase.
  a_an_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(an_q ^ AN_OFF));
  a_an_dark_off_phase : assert property (@(posedge clk) disable iff (!rst_n)
    (state != ON) |-> (an_q == AN_OFF));

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: fixed vector table, hand sequences for the
// mid-frame corner cases, and a long random run against a frame-position model.
module tb_seven_seg_scan_driver;

  localparam int CLK_DIV      = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = 4 * CLK_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  seven_seg_scan_driver_if bus ();

  seven_seg_scan_driver #(
    .CLK_DIV          (CLK_DIV),
    .BLANK_CYCLES     (BLANK_CYCLES),
    .ANODE_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] idx;
    logic       tick;
  } vec_t;

  vec_t vecs[14];

  // Reference model: only "running" and the position within the 32-cycle frame.
  logic        model_run  = 1'b0;
  int          model_pos  = 0;
  logic [27:0] model_snap = '0;
  logic        model_check = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_run  <= 1'b0;
      model_pos  <= 0;
      model_snap <= '0;
    end else if (!bus.en) begin
      model_run <= 1'b0;
      model_pos <= 0;
    end else if (!model_run) begin
      model_run  <= 1'b1;
      model_pos  <= 0;
      model_snap <= bus.seven_seg;
    end else begin
      model_pos <= (model_pos + 1) % FRAME;
      if ((model_pos + 1) % FRAME == 0) model_snap <= bus.seven_seg;
    end
  end

  function automatic logic [13:0] model_expect(input logic run, input int pos,
                                               input logic [27:0] pat);
    int         slot;
    logic       lit;
    logic [3:0] one_hot;
    logic [6:0] p;
    if (!run) return {4'hF, 7'h7F, 2'd0, 1'b0};
    slot    = pos / CLK_DIV;
    lit     = (pos % CLK_DIV) >= BLANK_CYCLES;
    one_hot = 4'b0001 << slot;
    p       = pat[7*slot +: 7];
    return {lit ? ~one_hot : 4'hF, lit ? ~p : 7'h7F, 2'(slot), pos == 0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [27:0] pat);
    bus.en        = en;
    bus.seven_seg = pat;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.an, bus.seg, bus.digit_idx, bus.frame_tick});
  endfunction

  always @(negedge clk) begin
    if (model_check)
      checkOutput("model_outputs", outs(), 32'(model_expect(model_run, model_pos, model_snap)));
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [27:0] pat_a;
    logic [27:0] pat_b;
    logic        found;
    int          lit_cnt[4];

    pat_a = {7'h06, 7'h5B, 7'h4F, 7'h66};
    pat_b = {7'h7F, 7'h6D, 7'h07, 7'h77};

    vecs[0]  = '{0,  4'hF, 7'h7F, 2'd0, 1'b1};
    vecs[1]  = '{1,  4'hF, 7'h7F, 2'd0, 1'b0};
    vecs[2]  = '{2,  4'hE, 7'h19, 2'd0, 1'b0};
    vecs[3]  = '{7,  4'hE, 7'h19, 2'd0, 1'b0};
    vecs[4]  = '{8,  4'hF, 7'h7F, 2'd1, 1'b0};
    vecs[5]  = '{9,  4'hF, 7'h7F, 2'd1, 1'b0};
    vecs[6]  = '{10, 4'hD, 7'h30, 2'd1, 1'b0};
    vecs[7]  = '{15, 4'hD, 7'h30, 2'd1, 1'b0};
    vecs[8]  = '{16, 4'hF, 7'h7F, 2'd2, 1'b0};
    vecs[9]  = '{18, 4'hB, 7'h24, 2'd2, 1'b0};
    vecs[10] = '{26, 4'h7, 7'h79, 2'd3, 1'b0};
    vecs[11] = '{31, 4'h7, 7'h79, 2'd3, 1'b0};
    vecs[12] = '{32, 4'hF, 7'h7F, 2'd0, 1'b1};
    vecs[13] = '{34, 4'hE, 7'h19, 2'd0, 1'b0};

    // Reset held with enable high and the clock running.
    applyStimulus(1'b1, pat_a);
    for (int i = 0; i < 4; i++) begin
      step_cycle();
      checkOutput($sformatf("reset_hold_%0d", i), outs(), 32'({4'hF, 7'h7F, 2'd0, 1'b0}));
    end
    model_check = 1'b1;
    applyStimulus(1'b0, pat_a);
    rst_n = 1'b1;
    step_cycle();

    // Basic scan from idle.
    applyStimulus(1'b1, pat_a);
    for (int c = 0; c <= 34; c++) begin
      step_cycle();
      foreach (vecs[v])
        if (vecs[v].cyc == c)
          checkOutput($sformatf("vec_cyc%0d", c), outs(),
                      32'({vecs[v].an, vecs[v].seg, vecs[v].idx, vecs[v].tick}));
    end

    // Pattern change while digit 2 is lit.
    found = 1'b0;
    for (int i = 0; i < 2*FRAME && !found; i++) begin
      step_cycle();
      found = (bus.an == 4'hB);
    end
    checkOutput("wait_digit2_lit", 32'(found), 32'd1);
    applyStimulus(1'b1, pat_b);
    step_cycle();
    checkOutput("digit2_keeps_old", 32'(bus.seg), 32'h24);
    found = 1'b0;
    for (int i = 0; i < 2*FRAME && !found; i++) begin
      step_cycle();
      found = (bus.an == 4'h7);
    end
    checkOutput("wait_digit3_lit", 32'(found), 32'd1);
    checkOutput("digit3_keeps_old", 32'(bus.seg), 32'h79);
    found = 1'b0;
    for (int i = 0; i < 2*FRAME && !found; i++) begin
      step_cycle();
      found = bus.frame_tick;
    end
    checkOutput("wait_frame_tick", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 2*FRAME && !found; i++) begin
      step_cycle();
      found = (bus.an == 4'hE);
    end
    checkOutput("wait_digit0_lit", 32'(found), 32'd1);
    checkOutput("digit0_new_pattern", 32'(bus.seg), 32'h08);

    // Enable dropped during digit 1 ON, then restored.
    found = 1'b0;
    for (int i = 0; i < 2*FRAME && !found; i++) begin
      step_cycle();
      found = (bus.an == 4'hD);
    end
    checkOutput("wait_digit1_lit", 32'(found), 32'd1);
    applyStimulus(1'b0, pat_b);
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      checkOutput($sformatf("disabled_dark_%0d", i), outs(), 32'({4'hF, 7'h7F, 2'd0, 1'b0}));
    end
    applyStimulus(1'b1, pat_b);
    step_cycle();
    checkOutput("reenable_tick", outs(), 32'({4'hF, 7'h7F, 2'd0, 1'b1}));
    step_cycle();
    step_cycle();
    checkOutput("reenable_digit0", outs(), 32'({4'hE, 7'h08, 2'd0, 1'b0}));

    // Asynchronous reset mid-ON, checked before any further clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_now", outs(), 32'({4'hF, 7'h7F, 2'd0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    step_cycle();
    checkOutput("after_reset_tick", outs(), 32'({4'hF, 7'h7F, 2'd0, 1'b1}));
    step_cycle();
    step_cycle();
    checkOutput("after_reset_digit0", outs(), 32'({4'hE, 7'h08, 2'd0, 1'b0}));

    // Long random run: frame alignment, one-hot anodes and lit-cycle budget.
    applyStimulus(1'b0, pat_b);
    step_cycle();
    applyStimulus(1'b1, 28'($urandom));
    for (int f = 0; f < 1000; f++) begin
      for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
      for (int c = 0; c < FRAME; c++) begin
        step_cycle();
        checkOutput("frame_tick_position", 32'(bus.frame_tick), 32'(c == 0));
        checkOutput("an_onehot0", 32'($onehot0(~bus.an)), 32'd1);
        for (int d = 0; d < 4; d++)
          if (bus.an[d] == 1'b0) lit_cnt[d]++;
        if ($urandom_range(0, 7) == 0) bus.seven_seg = 28'($urandom);
      end
      for (int d = 0; d < 4; d++)
        checkOutput($sformatf("lit_cycles_d%0d", d), 32'(lit_cnt[d]), 32'(CLK_DIV - BLANK_CYCLES));
    end

    model_check = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
